// File: rtl/nbit_adder.sv
// N-bit ripple-carry adder with carry-in, carry-out and signed overflow.
// The sum, carry and overflow flag are registered, giving one cycle of latency.

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

module nbit_adder #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);
    typedef struct packed {
        logic [N-1:0] s;
        logic         cout;
        logic         ovf;
    } res_t;

    logic [N:0]   c;
    logic [N-1:0] s_next;
    res_t         res_d;
    res_t         res_q;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_bit
        fa_cell u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s_next[i]),
            .co (c[i+1])
        );
    end

    // Overflow: carry into the MSB differs from carry out of it.
    assign res_d.s    = s_next;
    assign res_d.cout = c[N];
    assign res_d.ovf  = c[N] ^ c[N-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) res_q <= '0;
        else        res_q <= res_d;
    end

    assign s    = res_q.s;
    assign cout = res_q.cout;
    assign ovf  = res_q.ovf;
endmodule

// File: tb/tb_nbit_adder.sv
// Bench for nbit_adder: directed vectors, reset/glitch behaviour, random and
// exhaustive sweeps against an arithmetic reference model.

module tb_nbit_adder;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         cin = 1'b0;
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    nbit_adder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] es, input logic ec, input logic eo);
        checks++;
        assert (s === es) else begin
            errors++;
            $error("FAIL %s s got %b exp %b", tag, s, es);
        end
        checks++;
        assert (cout === ec) else begin
            errors++;
            $error("FAIL %s cout got %b exp %b", tag, cout, ec);
        end
        checks++;
        assert (ovf === eo) else begin
            errors++;
            $error("FAIL %s ovf got %b exp %b", tag, ovf, eo);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    task automatic model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic mc,
                         output logic [N-1:0] es, output logic ec, output logic eo);
        int unsigned u;
        int sa, sb, ss;
        u  = int'(ma) + int'(mb) + int'(mc);
        es = N'(u % (1 << N));
        ec = (u >= (1 << N));
        sa = int'(ma) - (ma[N-1] ? (1 << N) : 0);
        sb = int'(mb) - (mb[N-1] ? (1 << N) : 0);
        ss = sa + sb + int'(mc);
        eo = (ss > (1 << (N-1)) - 1) || (ss < -(1 << (N-1)));
    endtask

    // Called one tick after a rising edge: drive, clock, check.
    task automatic step(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                        input logic tc, input logic [N-1:0] es, input logic ec, input logic eo);
        a = ta; b = tb; cin = tc;
        @(posedge clk); #1;
        chk(tag, es, ec, eo);
    endtask

    task automatic step_model(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                              input logic tc);
        logic [N-1:0] es;
        logic ec, eo;
        model(ta, tb, tc, es, ec, eo);
        step(tag, ta, tb, tc, es, ec, eo);
    endtask

    initial begin
        logic [N-1:0] ps;
        logic pc, po;

        // Power-on reset without any clock edge.
        #1 rst_n = 1'b0;
        #1 chk("por", '0, 1'b0, 1'b0);
        a = 4'b1111; b = 4'b0001;
        @(posedge clk); #1;
        chk("rst_hold", '0, 1'b0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("rst_rel_pre_edge", '0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("rst_rel_first", 4'b0000, 1'b1, 1'b0);

        step("add_0_0",    4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        step("add_8_1",    4'b1000, 4'b0001, 1'b0, 4'b1001, 1'b0, 1'b0);
        step("add_a_5",    4'b1010, 4'b0101, 1'b0, 4'b1111, 1'b0, 1'b0);
        step("add_1_0",    4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0);
        step("wrap_f_1",   4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
        step("wrap_1_f",   4'b0001, 4'b1111, 1'b0, 4'b0000, 1'b1, 1'b0);
        step("wrap_4_f",   4'b0100, 4'b1111, 1'b0, 4'b0011, 1'b1, 1'b0);
        step("wrap_c_8",   4'b1100, 4'b1000, 1'b0, 4'b0100, 1'b1, 1'b1);
        step("ovf_7_3",    4'b0111, 4'b0011, 1'b0, 4'b1010, 1'b0, 1'b1);
        step("mix_2_b",    4'b0010, 4'b1011, 1'b0, 4'b1101, 1'b0, 1'b0);
        step("mix_3_9",    4'b0011, 4'b1001, 1'b0, 4'b1100, 1'b0, 1'b0);
        step("cin_f_f",    4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);
        step("cin_0_0",    4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0);
        step("cin_7_0",    4'b0111, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b1);

        // Mid-cycle reset with a live nonzero result pending.
        step("pre_rst", 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
        #3 rst_n = 1'b0;
        #1 chk("rst_async", '0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("rst_mid_hold", '0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_rel", 4'b0000, 1'b1, 1'b0);

        // Input glitches between edges must not disturb the outputs.
        step("pre_glitch", 4'b0111, 4'b0011, 1'b0, 4'b1010, 1'b0, 1'b1);
        #1 a = 4'b1111; b = 4'b1111; cin = 1'b1;
        #2 a = 4'b0000; b = 4'b0101;
        #1 chk("glitch_hold", 4'b1010, 1'b0, 1'b1);
        step("post_glitch", 4'b0010, 4'b0010, 1'b0, 4'b0100, 1'b0, 1'b0);

        // Back-to-back random operands, new values every cycle.
        for (int i = 0; i < 200; i++) begin
            step_model("rand", N'($urandom), N'($urandom), 1'($urandom));
        end

        // Outputs hold between edges and reflect the previous cycle's inputs.
        step_model("hold_setup", 4'b1001, 4'b0110, 1'b1);
        model(4'b1001, 4'b0110, 1'b1, ps, pc, po);
        a = 4'b0101; b = 4'b0101; cin = 1'b0;
        #4 chk("hold_mid", ps, pc, po);

        // Exhaustive sweep.
        for (int i = 0; i < (1 << (2 * N + 1)); i++) begin
            step_model("exh", N'(i >> (N + 1)), N'(i >> 1), i[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks %0d", checks);
        $fatal(1, "timeout");
    end
endmodule
